// File: rtl/stream_write_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_write_if
// Description : Byte-stream handshake bundle (tdata/tlast/tvalid/tready).
//               The master drives data and valid; the slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_write_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/stream_write.sv
`default_nettype none
// ============================================================================
// Module      : stream_write
// Description : Stream source. Local pushes fill a DEPTH-entry FIFO; the head
//               is moved into a single output register that drives the
//               tdata/tlast/tvalid stream under downstream tready.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_write #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          op_en,
    input  wire logic [DW-1:0] Din,
    input  wire logic          din_last,
    input  wire logic          wr_en,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count,
    output logic               overflow,
    stream_write_if.master     strm
);

    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE        = (AW+1)'(1);

    // FIFO storage: {last, data}; contents are not reset on purpose
    logic [DW:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;

    // Output register
    logic [DW-1:0] r_tdata;
    logic          r_tlast;
    logic          r_tvalid;

    logic          w_push;
    logic          w_load;
    logic          w_tvalid_nxt;
    logic [AW:0]   w_count_nxt;

    // Handshake decisions: the registered full refuses a push even when a
    // load frees a slot in the same edge; loads only fill a free or draining OR
    always_comb begin
        w_push = wr_en && !r_full;
        w_load = (r_count != '0) && op_en && (!r_tvalid || strm.tready);
    end

    // Next occupancy and next output-valid, used to register full/empty
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_load})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
        w_tvalid_nxt = r_tvalid;
        if (w_load) begin
            w_tvalid_nxt = 1'b1;
        end else if (r_tvalid && strm.tready) begin
            w_tvalid_nxt = 1'b0;
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {din_last, Din};
        end
    end

    // Pointers and status flags, all updated in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_COUNT);
            r_empty <= (w_count_nxt == '0) && !w_tvalid_nxt;
        end
    end

    // Output register: load the FIFO head, or release on acceptance;
    // data and last are held while the beat waits for tready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else begin
            r_tvalid <= w_tvalid_nxt;
            if (w_load) begin
                {r_tlast, r_tdata} <= r_mem[r_rd_ptr];
            end
        end
    end

    assign full        = r_full;
    assign empty       = r_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign strm.tdata  = r_tdata;
    assign strm.tlast  = r_tlast;
    assign strm.tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_stream_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_write
// Description : Randomised scoreboard bench for stream_write. A queue-based
//               reference model predicts flags and the output register; a
//               separate monitor pops expected beats on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_write;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_en;
    logic [DW-1:0] Din;
    logic          din_last;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    stream_write_if #(.DW(DW)) bus ();

    stream_write #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_en    (op_en),
        .Din      (Din),
        .din_last (din_last),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .strm     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of beats expected on the stream, in order
    logic [DW:0] sb[$];
    // Reference model: items waiting in the FIFO, output slot, sticky overflow
    logic [DW:0] m_fifo[$];
    bit          m_or;
    logic [DW:0] m_or_data;
    bit          m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances with the same inputs
    task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit last,
                         input bit op, input bit rdy);
        bit push_ok;
        bit load;
        bit acc;
        wr_en      = wr;
        Din        = d;
        din_last   = last;
        op_en      = op;
        bus.tready = rdy;
        push_ok = wr && (m_fifo.size() < DEPTH);
        load    = (m_fifo.size() > 0) && op && (!m_or || rdy);
        acc     = m_or && rdy;
        if (wr && !push_ok) m_ovf = 1'b1;
        if (load) begin
            m_or_data = m_fifo.pop_front();
            m_or      = 1'b1;
        end else if (acc) begin
            m_or = 1'b0;
        end
        if (push_ok) begin
            m_fifo.push_back({last, d});
            sb.push_back({last, d});
        end
        @(posedge clk);
        #1;
        chk("tvalid",   int'(bus.tvalid), int'(m_or));
        chk("count",    int'(count),      m_fifo.size());
        chk("full",     int'(full),       int'(m_fifo.size() == DEPTH));
        chk("empty",    int'(empty),      int'(m_fifo.size() == 0 && !m_or));
        chk("overflow", int'(overflow),   int'(m_ovf));
        if (m_or) chk("or_beat", int'({bus.tlast, bus.tdata}), int'(m_or_data));
    endtask

    task automatic idle(input bit op, input bit rdy);
        cycle(1'b0, '0, 1'b0, op, rdy);
    endtask

    task automatic model_reset();
        sb.delete();
        m_fifo.delete();
        m_or  = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Monitor: a beat is accepted at the next edge when valid and ready are
    // both high at the falling edge (inputs only change just after rising)
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.tvalid === 1'b1 && bus.tready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_beat: got 0x%0h expected no beat at %0t",
                         {bus.tlast, bus.tdata}, $time);
            end else begin
                chk("out_beat", int'({bus.tlast, bus.tdata}), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        int pushed;
        int guard;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        Din        = '0;
        din_last   = 1'b0;
        op_en      = 1'b0;
        bus.tready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", int'(bus.tvalid), 0);
        chk("rst_tdata",  int'(bus.tdata),  0);
        chk("rst_empty",  int'(empty),      1);
        chk("rst_count",  int'(count),      0);
        rst_n = 1'b1;

        // Latency: push at edge N, visible after N+1, gone after N+2
        cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
        chk("lat_n_tvalid", int'(bus.tvalid), 0);
        idle(1'b1, 1'b1);
        chk("lat_n1_tvalid", int'(bus.tvalid), 1);
        chk("lat_n1_tdata",  int'(bus.tdata),  8'hA5);
        idle(1'b1, 1'b1);
        chk("lat_n2_tvalid", int'(bus.tvalid), 0);

        // Backpressure
        cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1, 1'b0);
            chk("bp_hold_tdata", int'(bus.tdata), 8'h11);
            chk("bp_hold_count", int'(count),     2);
        end
        idle(1'b1, 1'b1);
        chk("bp_second", int'(bus.tdata), 8'h22);
        idle(1'b1, 1'b1);
        chk("bp_third",  int'(bus.tdata), 8'h33);
        idle(1'b1, 1'b1);
        chk("bp_done",   int'(bus.tvalid), 0);

        // op_en gating
        cycle(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
        chk("gate_or", int'(bus.tdata), 8'h40);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b1);
            chk("gate_tvalid", int'(bus.tvalid), 0);
            chk("gate_count",  int'(count),      1);
        end
        idle(1'b1, 1'b1);
        chk("gate_release", int'(bus.tdata), 8'h41);
        idle(1'b1, 1'b1);

        // Full and overflow
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            if (i == 16) begin
                chk("full_count", int'(count),    16);
                chk("full_flag",  int'(full),     1);
                chk("full_ovf0",  int'(overflow), 0);
            end
        end
        chk("ovf_set",  int'(overflow),  1);
        chk("ovf_or",   int'(bus.tdata), 8'h00);
        for (int i = 0; i < 20; i++) idle(1'b1, 1'b1);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset mid-stream with a beat pending
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_tvalid", int'(bus.tvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid",   int'(bus.tvalid), 0);
        chk("arst_empty",    int'(empty),      1);
        chk("arst_count",    int'(count),      0);
        chk("arst_overflow", int'(overflow),   0);
        chk("arst_full",     int'(full),       0);
        model_reset();
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Wrap and tlast with random backpressure and gaps
        pushed = 0;
        guard  = 0;
        while ((pushed < 40 || sb.size() != 0 || m_or) && guard < 2000) begin
            bit wr;
            wr = (pushed < 40) && (m_fifo.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            cycle(wr, 8'($urandom), (pushed % 8) == 7, 1'b1, 1'($urandom_range(0, 1)));
            if (wr) pushed++;
            guard++;
        end
        chk("wrap_timeout", int'(guard < 2000), 1);
        idle(1'b1, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
